// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the EX/WB stage: branch-type encoding and default widths.
package ex_wb_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RA_W   = 6;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_Z    = 2'b01,
    BR_N    = 2'b10,
    BR_JUMP = 2'b11
  } br_type_e;

endpackage

// File: rtl/ex_wb_stage_branch_resolve.sv
// Combinational branch decision from branch type and architectural Z/N flags.
module branch_resolve
  import ex_wb_stage_pkg::*;
(
  input  br_type_e br_type_i,
  input  logic     flag_z_i,
  input  logic     flag_n_i,
  output logic     taken_o
);

  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no path infers a latch.
    taken_o = 1'b0;
    case (br_type_i)
      BR_Z:    taken_o = flag_z_i;
      BR_N:    taken_o = flag_n_i;
      BR_JUMP: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB holding register with valid/ready handshake, Z/N flag register,
// branch redirect pulse and retired-instruction counter.
module ex_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_set_flags,
  input  logic [1:0]        ex_br_type,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_reg_we,
  output logic              flag_z,
  output logic              flag_n,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [CNT_W-1:0]  retired_cnt
);

  import ex_wb_stage_pkg::*;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic [RA_W-1:0]   wb_rd_q,    wb_rd_d;
  logic              wb_we_q,    wb_we_d;
  logic              flag_z_q,   flag_z_d;
  logic              flag_n_q,   flag_n_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic accept;
  logic consume;
  logic br_hit;

  assign ex_ready = !wb_valid_q || wb_ready;
  assign accept   = ex_valid && ex_ready && !flush;
  assign consume  = wb_valid_q && wb_ready && !flush;

  // Branches resolve against the flags as they stood before this instruction.
  branch_resolve u_branch_resolve (
    .br_type_i (br_type_e'(ex_br_type)),
    .flag_z_i  (flag_z_q),
    .flag_n_i  (flag_n_q),
    .taken_o   (br_hit)
  );

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    br_target_d = br_target_q;
    br_taken_d  = accept && br_hit;
    cnt_d       = consume ? cnt_q + CNT_W'(1) : cnt_q;

    if (accept) begin
      wb_valid_d = 1'b1;
      wb_data_d  = alu_out;
      wb_rd_d    = ex_rd;
      wb_we_d    = ex_reg_we;
      if (ex_set_flags) begin
        flag_z_d = alu_z;
        flag_n_d = alu_n;
      end
      if (br_hit) begin
        br_target_d = ex_br_target;
      end
    end else if (consume || flush) begin
      // A flushed entry is dropped without counting as retired.
      wb_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      cnt_q       <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_reg_we   = wb_valid_q && wb_we_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign retired_cnt = cnt_q;

endmodule
